// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - lsu_state_e : FSM state encoding (IDLE, BUSY, DONE)
//   - STORE_* / LOAD_* : StoreSrc / LoadSrc codes shared with the decoder
//   - SIZE_*      : internal access-size encoding
//   - store_size / load_size : map a decoder code onto an access size
`timescale 1ns/1ps
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    localparam logic [1:0] STORE_SW = 2'b00;
    localparam logic [1:0] STORE_SH = 2'b01;
    localparam logic [1:0] STORE_SB = 2'b10;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    localparam logic [1:0] SIZE_B   = 2'd0;
    localparam logic [1:0] SIZE_H   = 2'd1;
    localparam logic [1:0] SIZE_W   = 2'd2;
    localparam logic [1:0] SIZE_BAD = 2'd3;  // reserved code

    function automatic logic [1:0] store_size(input logic [1:0] src);
        case (src)
            STORE_SW: return SIZE_W;
            STORE_SH: return SIZE_H;
            STORE_SB: return SIZE_B;
            default:  return SIZE_BAD;
        endcase
    endfunction

    function automatic logic [1:0] load_size(input logic [2:0] src);
        case (src)
            LOAD_LB, LOAD_LBU: return SIZE_B;
            LOAD_LH, LOAD_LHU: return SIZE_H;
            LOAD_LW:           return SIZE_W;
            default:           return SIZE_BAD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: word-oriented memory bus between the load/store unit and memory.
//   MemReq/MemWe/MemAddr/MemWdata/MemBe : request side, driven by the LSU
//   MemAck/MemRdata                     : completion side, driven by memory
`timescale 1ns/1ps
interface lsu_if;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWdata;
    logic [3:0]  MemBe;
    logic        MemAck;
    logic [31:0] MemRdata;

    modport master (
        output MemReq, MemWe, MemAddr, MemWdata, MemBe,
        input  MemAck, MemRdata
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemWdata, MemBe,
        output MemAck, MemRdata
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane logic.
//   Request side : is_store/store_src/load_src/addr_lo/store_data
//                  -> be (byte enables), wdata (lane-replicated), illegal
//   Response side: rsp_off/rsp_load_src/rsp_word -> load_data (extended)
`timescale 1ns/1ps
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [1:0]  store_src,
    input  logic [2:0]  load_src,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        illegal,
    input  logic [1:0]  rsp_off,
    input  logic [2:0]  rsp_load_src,
    input  logic [31:0] rsp_word,
    output logic [31:0] load_data
);
    logic [1:0]  size;
    logic [31:0] shifted;

    assign size = is_store ? store_size(store_src) : load_size(load_src);

    always_comb begin
        illegal = 1'b0;
        be      = 4'b0000;
        case (size)
            SIZE_B: be = 4'b0001 << addr_lo;
            SIZE_H: begin
                be      = 4'b0011 << addr_lo;
                illegal = addr_lo[0];
            end
            SIZE_W: begin
                be      = 4'b1111;
                illegal = (addr_lo != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

    // Replicate the low byte/half across all lanes so memory only needs
    // the byte enables to pick the right one.
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata[8*gi +: 8] = (size == SIZE_B) ? store_data[7:0] :
                                  (size == SIZE_H) ? store_data[8*(gi%2) +: 8] :
                                                     store_data[8*gi +: 8];
    end

    // Bring the addressed byte/half down to bit 0, then extend.
    assign shifted = rsp_word >> {rsp_off, 3'b000};

    always_comb begin
        case (rsp_load_src)
            LOAD_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            LOAD_LH:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            LOAD_LW:  load_data = rsp_word;
            LOAD_LBU: load_data = {24'd0, shifted[7:0]};
            LOAD_LHU: load_data = {16'd0, shifted[15:0]};
            default:  load_data = 32'd0;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: Memory-stage load/store sequencer.
//   clk, reset          : clock, synchronous active-high reset
//   MemReadM/MemWriteM  : load/store in the Memory stage
//   StoreSrcM/LoadSrcM  : access width / extension codes
//   ALUResultM          : byte address; WriteDataM : store data
//   ReadDataM           : extended load result (valid in DONE only)
//   StallLSU            : freezes the upstream pipeline during an access
//   FaultM              : misaligned / reserved / conflicting access
//   bus                 : memory bus (master side)
// A legal access takes IDLE -> BUSY (request held until MemAck) -> DONE.
`timescale 1ns/1ps
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [1:0]  StoreSrcM,
    input  logic [2:0]  LoadSrcM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallLSU,
    output logic        FaultM,
    lsu_if.master       bus
);
    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  off_q, off_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  ld_src_q, ld_src_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;

    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        req_illegal;
    logic [31:0] load_data;

    lsu_align u_align (
        .is_store     (MemWriteM),
        .store_src    (StoreSrcM),
        .load_src     (LoadSrcM),
        .addr_lo      (ALUResultM[1:0]),
        .store_data   (WriteDataM),
        .be           (req_be),
        .wdata        (req_wdata),
        .illegal      (req_illegal),
        .rsp_off      (off_q),
        .rsp_load_src (ld_src_q),
        .rsp_word     (rdata_q),
        .load_data    (load_data)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        off_d     = off_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        ld_src_d  = ld_src_q;
        we_d      = we_q;
        rdata_d   = rdata_q;
        StallLSU  = 1'b0;
        FaultM    = 1'b0;
        ReadDataM = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (MemReadM || MemWriteM) begin
                    if ((MemReadM && MemWriteM) || req_illegal) begin
                        // Rejected without touching the bus; the pipeline
                        // moves on, so this is a single-cycle pulse.
                        FaultM = 1'b1;
                    end else begin
                        StallLSU = 1'b1;
                        state_d  = ST_BUSY;
                        addr_d   = {ALUResultM[31:2], 2'b00};
                        off_d    = ALUResultM[1:0];
                        be_d     = req_be;
                        wdata_d  = req_wdata;
                        ld_src_d = LoadSrcM;
                        we_d     = MemWriteM;
                    end
                end
            end
            ST_BUSY: begin
                StallLSU = 1'b1;
                if (bus.MemAck) begin
                    rdata_d = bus.MemRdata;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Stall drops here so the held instruction retires; going
                // straight to IDLE means it is never issued twice.
                state_d = ST_IDLE;
                if (!we_q) ReadDataM = load_data;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= 32'd0;
            off_q    <= 2'd0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            ld_src_q <= 3'd0;
            we_q     <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            off_q    <= off_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            ld_src_q <= ld_src_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
        end
    end

    // Bus outputs come straight from the latched request so they are
    // stable for the whole BUSY period.
    assign bus.MemReq   = (state_q == ST_BUSY);
    assign bus.MemWe    = (state_q == ST_BUSY) && we_q;
    assign bus.MemAddr  = addr_q;
    assign bus.MemWdata = wdata_q;
    assign bus.MemBe    = be_q;
endmodule
